// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder family.
// Opcode encodings, stage-count helper and configuration legality check.
package cla_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int unsigned nseg(input int unsigned width, input int unsigned seg_width);
        return (seg_width == 0) ? 1 : width / seg_width;
    endfunction

    // Segments are built from 4-bit CLA groups and must tile the operand exactly.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned seg_width);
        return (seg_width != 0) && (seg_width % 4 == 0) &&
               (width >= seg_width) && (width % seg_width == 0);
    endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_WIDTH-bit carry-lookahead adder: 4-bit CLA groups whose
// group generate/propagate feed a single lookahead carry unit.
module cla_segment #(
    parameter int unsigned SEG_WIDTH = 16
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 c_in,
    output logic [SEG_WIDTH-1:0] s,
    output logic                 c_out
);

    localparam int unsigned NGRP = SEG_WIDTH / 4;

    logic [SEG_WIDTH-1:0] p, g, c;
    logic [NGRP-1:0]      gp, gg;
    logic [NGRP:0]        gc;
    logic                 pp;

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gp = '0;
        gg = '0;
        gc = '0;
        c  = '0;
        pp = 1'b0;

        for (int unsigned j = 0; j < NGRP; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
                    ((&p[4*j+1 +: 3]) & g[4*j]);
        end

        // Lookahead unit: each group carry is a flat sum of products, not a ripple.
        gc[0] = c_in;
        for (int unsigned j = 0; j < NGRP; j++) begin
            gc[j+1] = gg[j];
            pp      = gp[j];
            for (int unsigned i = 0; i < j; i++) begin
                gc[j+1] = gc[j+1] | (pp & gg[j-1-i]);
                pp      = pp & gp[j-1-i];
            end
            gc[j+1] = gc[j+1] | (pp & c_in);
        end

        for (int unsigned j = 0; j < NGRP; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                       (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end

        s     = p ^ c;
        c_out = gc[NGRP];
    end

endmodule

// File: rtl/cla_pipelined_adder.sv
// Pipelined CLA adder/subtractor: one SEG_WIDTH segment resolved per stage,
// carry registered between stages, valid/ready flow control with bubble collapse.
module cla_pipelined_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SEG_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NSEG = nseg(WIDTH, SEG_WIDTH);
    localparam int unsigned LAST = NSEG - 1;

    if (!cfg_ok(WIDTH, SEG_WIDTH)) begin : g_cfg_check
        $error("cla_pipelined_adder: WIDTH must be a multiple of SEG_WIDTH, SEG_WIDTH a multiple of 4");
    end

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign b_eff = (sub == OP_ADD) ? in2 : ~in2;
    assign c_eff = (sub == OP_SUB) ? 1'b1 : c_in;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic             v_q, v_d, c_q, c_d, am_q, am_d, en;
        logic             src_v, src_c, src_am, seg_co;
        logic [WIDTH-1:0] acc_q, acc_d, b_q, b_d, src_acc, src_b;
        logic [SEG_WIDTH-1:0] seg_sum;

        // acc carries finished sum segments below k and untouched A bits above.
        if (k == 0) begin : g_src
            assign src_v   = in_valid;
            assign src_acc = in1;
            assign src_b   = b_eff;
            assign src_c   = c_eff;
            assign src_am  = in1[WIDTH-1];
        end else begin : g_src
            assign src_v   = g_stage[k-1].v_q;
            assign src_acc = g_stage[k-1].acc_q;
            assign src_b   = g_stage[k-1].b_q;
            assign src_c   = g_stage[k-1].c_q;
            assign src_am  = g_stage[k-1].am_q;
        end

        if (k == LAST) begin : g_en
            assign en = ~v_q | out_ready;
        end else begin : g_en
            assign en = ~v_q | g_stage[k+1].en;
        end

        cla_segment #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
            .a     (src_acc[k*SEG_WIDTH +: SEG_WIDTH]),
            .b     (src_b[k*SEG_WIDTH +: SEG_WIDTH]),
            .c_in  (src_c),
            .s     (seg_sum),
            .c_out (seg_co)
        );

        always_comb begin
            v_d   = v_q;
            acc_d = acc_q;
            b_d   = b_q;
            c_d   = c_q;
            am_d  = am_q;
            if (en) begin
                v_d = src_v;
                if (src_v) begin
                    acc_d = src_acc;
                    acc_d[k*SEG_WIDTH +: SEG_WIDTH] = seg_sum;
                    b_d   = src_b;
                    c_d   = seg_co;
                    am_d  = src_am;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                acc_q <= '0;
                b_q   <= '0;
                c_q   <= 1'b0;
                am_q  <= 1'b0;
            end else begin
                v_q   <= v_d;
                acc_q <= acc_d;
                b_q   <= b_d;
                c_q   <= c_d;
                am_q  <= am_d;
            end
        end
    end

    assign in_ready  = g_stage[0].en;
    assign out_valid = g_stage[LAST].v_q;
    assign sum       = g_stage[LAST].acc_q;
    assign c_out     = g_stage[LAST].c_q;
    assign ovf       = (g_stage[LAST].am_q == g_stage[LAST].b_q[WIDTH-1]) &
                       (g_stage[LAST].acc_q[WIDTH-1] != g_stage[LAST].am_q);
    // Qualified by valid so the flag reads 0 out of reset, like the other outputs.
    assign zero      = g_stage[LAST].v_q & ~|g_stage[LAST].acc_q;

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Self-checking bench: directed literal cases and backpressure/reset on a 32/16
// instance, randomized handshake stream on a 64/8 instance, both against a model.
module tb_cla_pipelined_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        c_out;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int unsigned cycle = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    logic        x32_in_valid, x32_in_ready, x32_c_in, x32_sub;
    logic        x32_out_valid, x32_out_ready, x32_c_out, x32_ovf, x32_zero;
    logic [31:0] x32_in1, x32_in2, x32_sum;

    logic        x64_in_valid, x64_in_ready, x64_c_in, x64_sub;
    logic        x64_out_valid, x64_out_ready, x64_c_out, x64_ovf, x64_zero;
    logic [63:0] x64_in1, x64_in2, x64_sum;

    cla_pipelined_adder #(.WIDTH(32), .SEG_WIDTH(16)) dut32 (
        .clk(clk), .rst(rst), .in_valid(x32_in_valid), .in_ready(x32_in_ready),
        .in1(x32_in1), .in2(x32_in2), .c_in(x32_c_in), .sub(x32_sub),
        .out_valid(x32_out_valid), .out_ready(x32_out_ready), .sum(x32_sum),
        .c_out(x32_c_out), .ovf(x32_ovf), .zero(x32_zero)
    );

    cla_pipelined_adder #(.WIDTH(64), .SEG_WIDTH(8)) dut64 (
        .clk(clk), .rst(rst), .in_valid(x64_in_valid), .in_ready(x64_in_ready),
        .in1(x64_in1), .in2(x64_in2), .c_in(x64_c_in), .sub(x64_sub),
        .out_valid(x64_out_valid), .out_ready(x64_out_ready), .sum(x64_sum),
        .c_out(x64_c_out), .ovf(x64_ovf), .zero(x64_zero)
    );

    // Reference: plain integer arithmetic; overflow from the signed result range.
    function automatic res_t model(input logic [63:0] a_in, input logic [63:0] b_in,
                                   input logic cin, input logic sb, input int unsigned w);
        logic [63:0] mask, a, b;
        logic [65:0] full;
        logic signed [65:0] sa, sbv, sr, lim;
        res_t r;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (sb) full = {2'b00, a} + {2'b00, ~b & mask} + 66'd1;
        else    full = {2'b00, a} + {2'b00, b} + {65'd0, cin};
        r.sum   = full[63:0] & mask;
        r.c_out = full[w];
        sa  = $signed({2'b00, a});
        sbv = $signed({2'b00, b});
        if (a[w-1]) sa  = sa  - (66'sd1 <<< w);
        if (b[w-1]) sbv = sbv - (66'sd1 <<< w);
        sr  = sb ? (sa - sbv) : (sa + sbv + $signed({65'd0, cin}));
        lim = 66'sd1 <<< (w - 1);
        r.ovf  = (sr >= lim) || (sr < -lim);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic set_in(input bit wide, input logic v, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sb);
        if (wide) begin
            x64_in_valid = v; x64_in1 = a; x64_in2 = b; x64_c_in = cin; x64_sub = sb;
        end else begin
            x32_in_valid = v; x32_in1 = a[31:0]; x32_in2 = b[31:0]; x32_c_in = cin; x32_sub = sb;
        end
    endtask

    function automatic res_t dut_res(input bit wide);
        res_t r;
        r.sum   = wide ? x64_sum : {32'd0, x32_sum};
        r.c_out = wide ? x64_c_out : x32_c_out;
        r.ovf   = wide ? x64_ovf : x32_ovf;
        r.zero  = wide ? x64_zero : x32_zero;
        return r;
    endfunction

    // Scoreboards: expected results and acceptance cycles, in order.
    res_t q32[$], q64[$];
    int unsigned t32[$], t64[$];

    always @(negedge clk) begin
        res_t e;
        int unsigned lat;
        if (rst) begin
            q32.delete(); t32.delete();
        end else begin
            if (x32_out_valid && x32_out_ready) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL out32_spurious got sum=%h expected no result", x32_sum);
                end else begin
                    e = q32.pop_front();
                    lat = cycle - t32.pop_front();
                    if ({x32_sum, x32_c_out, x32_ovf, x32_zero} !== {e.sum[31:0], e.c_out, e.ovf, e.zero} || lat < 2) begin
                        errors++;
                        $display("FAIL out32_model got sum=%h c=%b o=%b z=%b lat=%0d expected sum=%h c=%b o=%b z=%b lat>=2",
                                 x32_sum, x32_c_out, x32_ovf, x32_zero, lat, e.sum[31:0], e.c_out, e.ovf, e.zero);
                    end
                end
            end
            if (x32_in_valid && x32_in_ready) begin
                q32.push_back(model({32'd0, x32_in1}, {32'd0, x32_in2}, x32_c_in, x32_sub, 32));
                t32.push_back(cycle);
            end
        end
    end

    always @(negedge clk) begin
        res_t e;
        int unsigned lat;
        if (rst) begin
            q64.delete(); t64.delete();
        end else begin
            if (x64_out_valid && x64_out_ready) begin
                checks++;
                if (q64.size() == 0) begin
                    errors++;
                    $display("FAIL out64_spurious got sum=%h expected no result", x64_sum);
                end else begin
                    e = q64.pop_front();
                    lat = cycle - t64.pop_front();
                    if ({x64_sum, x64_c_out, x64_ovf, x64_zero} !== {e.sum, e.c_out, e.ovf, e.zero} || lat < 8) begin
                        errors++;
                        $display("FAIL out64_model got sum=%h c=%b o=%b z=%b lat=%0d expected sum=%h c=%b o=%b z=%b lat>=8",
                                 x64_sum, x64_c_out, x64_ovf, x64_zero, lat, e.sum, e.c_out, e.ovf, e.zero);
                    end
                end
            end
            if (x64_in_valid && x64_in_ready) begin
                q64.push_back(model(x64_in1, x64_in2, x64_c_in, x64_sub, 64));
                t64.push_back(cycle);
            end
        end
    end

    // One beat into an idle pipeline; result must appear exactly n cycles later.
    task automatic directed(input bit wide, input int unsigned n, input string name,
                            input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sb,
                            input logic [63:0] es, input logic ec, input logic eo, input logic ez);
        res_t r;
        @(posedge clk); #1;
        set_in(wide, 1'b1, a, b, cin, sb);
        if (wide) x64_out_ready = 1'b1; else x32_out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_accept"}, wide ? x64_in_ready : x32_in_ready, 64'd1);
        @(posedge clk); #1;
        set_in(wide, 1'b0, a, b, cin, sb);
        for (int i = 1; i < int'(n); i++) begin
            @(negedge clk);
            chk({name, "_early"}, wide ? x64_out_valid : x32_out_valid, 64'd0);
        end
        @(negedge clk);
        chk({name, "_valid"}, wide ? x64_out_valid : x32_out_valid, 64'd1);
        r = dut_res(wide);
        chk({name, "_sum"}, r.sum, es);
        chk({name, "_flags"}, {61'd0, r.c_out, r.ovf, r.zero}, {61'd0, ec, eo, ez});
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'hFFFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'd0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int idx, got, gaps, stale, acc;
        res_t r;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        x32_out_ready = 1'b0;
        x64_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            r = dut_res(w == 1);
            chk("reset_out_valid", (w == 1) ? x64_out_valid : x32_out_valid, 64'd0);
            chk("reset_sum", r.sum, 64'd0);
            chk("reset_flags", {61'd0, r.c_out, r.ovf, r.zero}, 64'd0);
            chk("reset_in_ready", (w == 1) ? x64_in_ready : x32_in_ready, 64'd1);
        end

        directed(1'b0, 2, "seg_carry", 64'h0000FFFF, 64'h1, 1'b0, 1'b0, 64'h00010000, 1'b0, 1'b0, 1'b0);
        directed(1'b0, 2, "wrap",      64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        directed(1'b0, 2, "add_ovf",   64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 64'h80000000, 1'b0, 1'b1, 1'b0);
        directed(1'b0, 2, "sub_ovf",   64'h7FFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b1, 64'h80000000, 1'b0, 1'b1, 1'b0);
        directed(1'b0, 2, "sub_zero",  64'h5, 64'h5, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1);
        directed(1'b0, 2, "add_cin",   64'h1, 64'h2, 1'b1, 1'b0, 64'h4, 1'b0, 1'b0, 1'b0);
        directed(1'b1, 8, "w64_wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        directed(1'b1, 8, "w64_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

        // Backpressure: six beats k+k, consumer stalled for cycles 0-4.
        idx = 0; got = 0; gaps = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(posedge clk); #1;
            x32_out_ready = (cyc >= 5);
            set_in(1'b0, idx < 6, 64'(idx + 1), 64'(idx + 1), 1'b0, 1'b0);
            @(negedge clk);
            if (cyc >= 2 && cyc <= 4) chk("bp_in_ready_low", x32_in_ready, 64'd0);
            if (cyc == 4) chk("bp_accepted_two", 64'(idx), 64'd2);
            if (x32_in_valid && x32_in_ready) idx++;
            if (got > 0 && !x32_out_valid) gaps++;
            if (x32_out_valid && x32_out_ready) begin
                chk("bp_order", {32'd0, x32_sum}, 64'(2 * (got + 1)));
                got++;
            end
        end
        chk("bp_all_out", 64'(got), 64'd6);
        chk("bp_no_gap", 64'(gaps), 64'd0);

        // Reset with two beats in flight.
        @(posedge clk); #1;
        x32_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 1'b1, 64'(100 + i), 64'd7, 1'b0, 1'b0);
            @(negedge clk);
            chk("rst_pre_accept", x32_in_ready, 64'd1);
            @(posedge clk); #1;
        end
        set_in(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", x32_out_valid, 64'd0);
        chk("rst_mid_sum", {32'd0, x32_sum}, 64'd0);
        @(posedge clk); #1;
        x32_out_ready = 1'b1;
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (x32_out_valid) stale++;
        end
        chk("rst_no_stale", 64'(stale), 64'd0);

        // Random stream on the 64/8 instance with random handshakes.
        acc = 0;
        for (int cyc = 0; cyc < 20000 && acc < 1000; cyc++) begin
            @(posedge clk); #1;
            x64_out_ready = ($urandom_range(0, 9) < 7);
            set_in(1'b1, $urandom_range(0, 9) < 7, rnd64(), rnd64(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (x64_in_valid && x64_in_ready) acc++;
        end
        chk("rand_accepted", 64'(acc), 64'd1000);
        @(posedge clk); #1;
        set_in(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        x64_out_ready = 1'b1;
        for (int i = 0; i < 100 && q64.size() != 0; i++) @(negedge clk);
        chk("rand_drained", 64'(q64.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_pipelined_adder.md
Name: cla_pipelined_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor, successor to the fixed 32-bit two-segment CLA. Splits a WIDTH-bit operation into NSEG = WIDTH/SEG_WIDTH segments, one segment resolved per pipeline stage with the carry registered between stages. Adds add/sub mode, signed-overflow and zero flags, and valid/ready handshakes on both sides. Used by the ALU and address paths where timing closure needs a short carry chain.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of SEG_WIDTH.
SEG_WIDTH, 16, bits resolved per stage; must be a multiple of 4 (4-bit CLA groups plus a lookahead unit).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  adder accepts a beat this cycle
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
c_in  input  1  carry-in (add mode only)
sub  input  1  0 = A+B+c_in, 1 = A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
c_out  output  1  carry out of the MSB (no-borrow flag in sub mode)
ovf  output  1  two's-complement signed overflow
zero  output  1  sum == 0

Behaviour:
- Transfer on in_valid & in_ready (input) and out_valid & out_ready (output).
- Effective operand B' = sub ? ~in2 : in2. Effective carry-in = sub ? 1 : c_in; c_in is ignored when sub=1.
- Stage k (0..NSEG-1) adds segment k of A and B' using the carry registered by stage k-1 (stage 0 uses the effective carry-in). It registers the segment sum, carry-out, the not-yet-added upper operand bits, and the sub flag.
- Latency is exactly NSEG cycles from input transfer to out_valid, with no stalls. Throughput is 1 beat/cycle.
- Output signals:
  - sum and c_out come from the last stage's registers.
  - ovf = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]).
  - zero = ~|sum.
  - All outputs are registered or derived only from registered state. in_ready is the only combinational path from out_ready.
- Per-stage valid bit v[k]. Stage k advances when ~v[k] | adv[k+1]; the last stage advances when ~out_valid | out_ready.
- in_ready = ~v[0] | adv[1]. Bubbles collapse.
- Capacity is NSEG beats. In-order delivery; no beat is dropped or duplicated.
- A stalled stage holds all of its registers unchanged.
- Reset: all valid bits are 0, and every pipeline register, sum, c_out, ovf and zero is 0.
  - in_ready reads 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; no partial result appears afterwards.
- When the pipeline is full with a simultaneous input and output transfer in the same cycle, both transfers complete.
- No input transfer occurs while in_valid is low, regardless of in_ready.
- Wrap-around: results are modulo 2^WIDTH; c_out carries the lost bit.

Decomposition:
- Shared package cla_pkg:
  - localparams OP_ADD=1'b0, OP_SUB=1'b1;
  - function nseg(WIDTH, SEG_WIDTH);
  - elaboration-time checks for the divisibility rules.
- Sub-module cla_segment (combinational, SEG_WIDTH bits): built from 4-bit CLAs plus a lookahead carry unit; outputs segment sum and carry-out.
- The top module instantiates one cla_segment per stage and handles the skew registers and handshake.

Test Plan:
1. WIDTH=32, SEG_WIDTH=16; in1=0x0000FFFF, in2=0x00000001, c_in=0, sub=0 -> exactly 2 cycles later sum=0x00010000, c_out=0, ovf=0, zero=0 (carry crosses the segment boundary).
2. in1=0xFFFFFFFF, in2=0x00000001, add -> sum=0x00000000, c_out=1, zero=1, ovf=0. Then in1=0x7FFFFFFF, in2=1 -> sum=0x80000000, ovf=1, c_out=0.
3. sub=1, in1=0x7FFFFFFF, in2=0xFFFFFFFF, c_in=1 (ignored) -> sum=0x80000000, c_out=0, ovf=1. Then sub=1, 5-5 -> sum=0, c_out=1, zero=1.
4. Backpressure: stream 6 back-to-back beats (A=k, B=k, k=1..6), out_ready=0 for cycles 0-4.
   - in_ready falls after 2 beats are accepted.
   - On release, results arrive as 2, 4, 6, 8, 10, 12, in order, with no gaps once flowing.
5. Reset mid-flight: accept 2 beats, assert rst for 1 cycle -> out_valid=0 and sum=0 the next cycle, and no stale result appears afterwards.
6. WIDTH=64, SEG_WIDTH=8: random 1000 beats with random in_valid/out_ready -> latency is 8 when unstalled, every result matches a+b'+cin mod 2^64 with correct c_out/ovf/zero, and order is preserved.
